booth_r4_mul: RTL and testbench
===============================

# booth_r4_mul

Parametrised sequential radix-4 Booth multiplier with valid/ready handshakes on input and output, and per-operation signed/unsigned mode. It is the next generation of the team's radix-2 Booth multiplier. It retires two multiplier bits per clock and holds its result under output backpressure. It sits between an operand source and a result consumer in the datapath and handles one multiplication at a time.

## Interface
- DATA_WIDTH, default 8: operand width in bits; legal range 2..32, odd or even.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous, active-low.
- in_valid  in  1  operand source presents a, b, is_signed.
- in_ready  out  1  block can accept operands (IDLE only).
- a  in  DATA_WIDTH  multiplicand.
- b  in  DATA_WIDTH  multiplier.
- is_signed  in  1  1 = two's-complement operands, 0 = unsigned; sampled with a and b.
- out_valid  out  1  product is valid and held stable.
- out_ready  in  1  consumer accepts product.
- product  out  2*DATA_WIDTH  result; signed or unsigned according to the captured is_signed.
- busy  out  1  high in CALC and DONE.

## Operation
- Extended width: E = DATA_WIDTH+1, rounded up to even. Iteration count: N = E/2. With the default DATA_WIDTH=8, E=10 and N=5.
- Operand extension at accept:
  - Signed mode: a and b are sign-extended to E bits.
  - Unsigned mode: a and b are zero-extended to E bits.
- Internal state:
  - Accumulator, E+2 bits, one bit wider than the value of ±2·a.
  - Multiplier shift register: E bits plus an appended 0 LSB (b_{-1}).
- Each CALC iteration:
  - Examine triplet {b[2i+1], b[2i], b[2i-1]}.
  - Map the triplet to a partial product: 000/111→0, 001/010→+a, 011→+2a, 100→-2a, 101/110→-a.
  - Add the partial product to the accumulator.
  - Arithmetic-shift the combined {acc, mult} right by 2.
- Final product: the low 2*DATA_WIDTH bits of the combined register after N iterations. The result is exact in both modes; no overflow is possible.
- State machine:
  - IDLE: in_ready=1. On in_valid&&in_ready, capture a, b, is_signed, clear the accumulator, load counter=N, go to CALC.
  - CALC: one iteration per clock, counter decrements. When the iteration with counter==1 completes, load product and go to DONE.
  - DONE: out_valid=1 and product is held. When out_valid&&out_ready, go to IDLE.
- No new operands are accepted in CALC or DONE; in_valid is ignored there.
- Changes on a, b or is_signed after capture have no effect on the operation in flight.

## Timing
- Reset, sampled at a rising edge with rst==0:
  - state=IDLE, counter=0, accumulator=0.
  - in_ready=0, out_valid=0, busy=0, product=0.
- in_ready rises at the first edge where rst==1 is sampled; in_ready is a registered output.
- Latency: for an accept at edge T, out_valid=1 and product are valid after edge T+N.
- Output release: if out_ready=1 at edge T+N+1, then out_valid=0 and in_ready=1 after that edge.
- Throughput without backpressure: one result per N+2 cycles.
- Backpressure:
  - out_valid stays 1 and product stays constant for any number of cycles while out_ready=0.
  - out_ready while out_valid=0 has no effect.
- product keeps its last value after the output handshake until the next result loads; it changes only at the transition into DONE or on reset.
- busy=1 from the edge after accept through the edge of the output handshake.
- Reset mid-operation (CALC or DONE): the operation is abandoned with no output handshake and all outputs take their reset values at that edge.
- in_valid held high continuously: exactly one accept per IDLE visit.

## Test plan
- DATA_WIDTH=8, signed: a=-128, b=-128 → product 0x4000 (16384) after exactly 5 cycles. a=-1, b=1 → 0xFFFF. a=127, b=-128 → 0xC080 (-16256).
- DATA_WIDTH=8, unsigned: a=0xFF, b=0xFF → 0xFE01 (65025). The same bit patterns with is_signed=1 → 0x0001.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid. Product and out_valid must stay constant, in_ready=0 throughout, and in_valid pulses during that time must be ignored. Then release out_ready and check a single output handshake.
- Reset mid-CALC: assert rst=0 at cycle 2 after accept. out_valid=0, product=0 and busy=0 after that edge. After release, a=3, b=5 → 15 with normal latency.
- Random: 1000 operations per mode, with random in_valid/out_ready gaps, compared against the behavioural a*b. Run at DATA_WIDTH=8 (N=5), DATA_WIDTH=7 (N=4) and DATA_WIDTH=16 (N=9), checking latency N on every operation.
- Corner operands in both modes: 0×anything=0, minimum×1, maximum×maximum, minimum×minimum.

Source files
------------

// File: rtl/booth_r4_mul.sv
// Sequential radix-4 Booth multiplier with valid/ready handshakes and per-operation
// signed/unsigned mode; retires two multiplier bits per clock.
module booth_r4_mul #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [DATA_WIDTH-1:0]     a,
   input  logic [DATA_WIDTH-1:0]     b,
   input  logic                      is_signed,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [2*DATA_WIDTH-1:0]   product,
   output logic                      busy
);

   // Operands are extended by at least one bit so unsigned values stay positive
   // under signed Booth recoding; E is kept even so every iteration sees a full pair.
   localparam int E    = DATA_WIDTH + 1 + ((DATA_WIDTH + 1) % 2);
   localparam int N    = E / 2;
   localparam int AW   = E + 2;
   localparam int MW   = E + 1;
   localparam int CW   = AW + MW;
   localparam int PW   = 2 * DATA_WIDTH;
   localparam int XW   = E - DATA_WIDTH;
   localparam int CNTW = $clog2(N + 1);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_t;

   state_t                state, state_nx;
   logic [CNTW-1:0]       cnt;
   logic [E-1:0]          mcand;
   logic [AW-1:0]         acc;
   logic [AW-1:0]         mcand_x;
   logic [AW-1:0]         pp;
   logic [AW-1:0]         acc_sum;
   logic [MW-1:0]         mult;
   logic signed [CW-1:0]  comb;
   logic signed [CW-1:0]  comb_sh;
   logic                  accept;
   logic                  last_iter;

   function automatic logic [E-1:0] extend(input logic [DATA_WIDTH-1:0] v, input logic sgn);
      return {{XW{sgn & v[DATA_WIDTH-1]}}, v};
   endfunction

   assign accept    = in_valid && in_ready;
   assign last_iter = (state == CALC) && (cnt == CNTW'(1));

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst) state <= IDLE;
      else      state <= state_nx;
   end

   // NOTE: every always_comb output gets a default first, otherwise an unassigned path infers a latch.
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (accept)    state_nx = CALC;
         CALC:    if (last_iter) state_nx = DONE;
         DONE:    if (out_ready) state_nx = IDLE;
         default:                state_nx = IDLE;
      endcase
   end

   // Handshake outputs are registered from the next state, so in_ready stays low
   // during the first cycle after reset release.
   always_ff @(posedge clk) begin
      if (!rst) begin
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         in_ready  <= (state_nx == IDLE);
         out_valid <= (state_nx == DONE);
         busy      <= (state_nx != IDLE);
      end
   end

   always_comb begin
      mcand_x = {{2{mcand[E-1]}}, mcand};
      pp      = '0;
      unique case (mult[2:0])
         3'b001, 3'b010: pp = mcand_x;
         3'b011:         pp = mcand_x << 1;
         3'b100:         pp = -(mcand_x << 1);
         3'b101, 3'b110: pp = -mcand_x;
         default:        pp = '0;
      endcase
      acc_sum = acc + pp;
      comb    = {acc_sum, mult};
      comb_sh = comb >>> 2;
   end

   // NOTE: datapath registers are reset too, because product and the accumulator have defined reset values.
   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt     <= '0;
         acc     <= '0;
         mult    <= '0;
         mcand   <= '0;
         product <= '0;
      end else if (accept) begin
         mcand <= extend(a, is_signed);
         mult  <= {extend(b, is_signed), 1'b0};
         acc   <= '0;
         cnt   <= CNTW'(N);
      end else if (state == CALC) begin
         acc  <= comb_sh[CW-1:MW];
         mult <= comb_sh[MW-1:0];
         cnt  <= cnt - CNTW'(1);
         // Bit 0 of the combined register is the b[-1] slot, so the product sits just above it.
         if (last_iter) product <= comb_sh[PW:1];
      end
   end

endmodule

// File: tb/tb_booth_r4_mul.sv
// Self-checking bench for booth_r4_mul at DATA_WIDTH 8, 7 and 16 against a plain
// arithmetic reference, with latency, backpressure and reset checks.
module tb_booth_r4_mul;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic        is_signed = 1'b0;
   logic [15:0] a_in = '0;
   logic [15:0] b_in = '0;
   int          sel = 8;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   logic iv8, ir8, ov8, bz8;
   logic iv7, ir7, ov7, bz7;
   logic iv16, ir16, ov16, bz16;
   logic [15:0] p8;
   logic [13:0] p7;
   logic [31:0] p16;

   assign iv8  = in_valid && (sel == 8);
   assign iv7  = in_valid && (sel == 7);
   assign iv16 = in_valid && (sel == 16);

   booth_r4_mul #(.DATA_WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8),
      .a(a_in[7:0]), .b(b_in[7:0]), .is_signed(is_signed),
      .out_valid(ov8), .out_ready(out_ready), .product(p8), .busy(bz8));

   booth_r4_mul #(.DATA_WIDTH(7)) dut7 (
      .clk(clk), .rst(rst), .in_valid(iv7), .in_ready(ir7),
      .a(a_in[6:0]), .b(b_in[6:0]), .is_signed(is_signed),
      .out_valid(ov7), .out_ready(out_ready), .product(p7), .busy(bz7));

   booth_r4_mul #(.DATA_WIDTH(16)) dut16 (
      .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16),
      .a(a_in), .b(b_in), .is_signed(is_signed),
      .out_valid(ov16), .out_ready(out_ready), .product(p16), .busy(bz16));

   logic        in_ready_m, out_valid_m, busy_m;
   logic [31:0] prod_m;

   always_comb begin
      in_ready_m  = ir8;
      out_valid_m = ov8;
      busy_m      = bz8;
      prod_m      = {16'h0, p8};
      if (sel == 7) begin
         in_ready_m  = ir7;
         out_valid_m = ov7;
         busy_m      = bz7;
         prod_m      = {18'h0, p7};
      end else if (sel == 16) begin
         in_ready_m  = ir16;
         out_valid_m = ov16;
         busy_m      = bz16;
         prod_m      = p16;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic int n_iter(input int w);
      int e;
      e = w + 1;
      if (e % 2 != 0) e++;
      return e / 2;
   endfunction

   // Reference: interpret the operand bits as signed or unsigned integers and multiply.
   function automatic logic [31:0] model(input int w, input logic [15:0] av,
                                         input logic [15:0] bv, input bit s);
      longint m, x, y, r;
      m = (longint'(1) << w) - 1;
      x = longint'(av) & m;
      y = longint'(bv) & m;
      if (s && av[w-1]) x = x - (longint'(1) << w);
      if (s && bv[w-1]) y = y - (longint'(1) << w);
      r = x * y;
      return 32'(r & ((longint'(1) << (2 * w)) - 1));
   endfunction

   task automatic do_op(input int w, input logic [15:0] av, input logic [15:0] bv,
                        input bit s, input int pre_gap, input int hold, input bit pulse,
                        output logic [31:0] res);
      logic [31:0] exp;
      int          lat;
      int          to;
      exp = model(w, av, bv, s);
      res = '0;
      sel = w;
      repeat (pre_gap) @(negedge clk);
      @(negedge clk);
      a_in      = av;
      b_in      = bv;
      is_signed = s;
      in_valid  = 1'b1;
      to = 0;
      while (!in_ready_m && to < 100) begin
         @(negedge clk);
         to++;
      end
      if (!in_ready_m) begin
         check("accept_timeout", 32'(in_ready_m), 32'd1);
         in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      a_in      = 16'($urandom);
      b_in      = 16'($urandom);
      is_signed = !s;
      lat = 0;
      while (!out_valid_m && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check($sformatf("latency_w%0d", w), 32'(lat), 32'(n_iter(w)));
      check($sformatf("product_w%0d_s%0d", w, s), prod_m, exp);
      check("busy_in_done", 32'(busy_m), 32'd1);
      res = prod_m;
      repeat (hold) begin
         if (pulse) begin
            in_valid = 1'($urandom);
            a_in     = 16'($urandom);
            b_in     = 16'($urandom);
         end
         @(posedge clk);
         #1;
         check("hold_valid", 32'(out_valid_m), 32'd1);
         check("hold_product", prod_m, exp);
         if (pulse) check("hold_in_ready", 32'(in_ready_m), 32'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check("release_valid", 32'(out_valid_m), 32'd0);
      check("release_in_ready", 32'(in_ready_m), 32'd1);
      check("release_busy", 32'(busy_m), 32'd0);
      check("product_after_release", prod_m, exp);
   endtask

   initial begin
      int          widths[3];
      logic [31:0] r;
      logic [15:0] mn, mx;
      int          pg, hd;
      widths = '{8, 7, 16};

      // Reset state, including in_valid asserted while in reset
      in_valid = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      foreach (widths[i]) begin
         sel = widths[i];
         #1;
         check("rst_in_ready", 32'(in_ready_m), 32'd0);
         check("rst_out_valid", 32'(out_valid_m), 32'd0);
         check("rst_busy", 32'(busy_m), 32'd0);
         check("rst_product", prod_m, 32'd0);
      end
      in_valid = 1'b0;
      sel = 8;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("ready_after_release", 32'(in_ready_m), 32'd1);
      check("idle_after_release", 32'(busy_m), 32'd0);

      // Directed DATA_WIDTH=8 values
      do_op(8, 16'h0080, 16'h0080, 1'b1, 0, 0, 1'b0, r);
      check("s8_min_min", r, 32'h4000);
      do_op(8, 16'h00FF, 16'h0001, 1'b1, 0, 0, 1'b0, r);
      check("s8_m1_x_1", r, 32'hFFFF);
      do_op(8, 16'h007F, 16'h0080, 1'b1, 0, 0, 1'b0, r);
      check("s8_max_min", r, 32'hC080);
      do_op(8, 16'h00FF, 16'h00FF, 1'b0, 0, 0, 1'b0, r);
      check("u8_ff_ff", r, 32'hFE01);
      do_op(8, 16'h00FF, 16'h00FF, 1'b1, 0, 0, 1'b0, r);
      check("s8_ff_ff", r, 32'h0001);

      // Backpressure for 20 cycles with in_valid pulses
      do_op(8, 16'h00B3, 16'h005D, 1'b0, 0, 20, 1'b1, r);
      check("bp_result", r, 32'h4107);
      @(posedge clk);
      #1;
      check("bp_no_phantom_accept", 32'(busy_m), 32'd0);

      // Reset two cycles after accept
      sel = 8;
      @(negedge clk);
      a_in = 16'd7;
      b_in = 16'd9;
      is_signed = 1'b0;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("midcalc_busy", 32'(busy_m), 32'd1);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("midcalc_rst_out_valid", 32'(out_valid_m), 32'd0);
      check("midcalc_rst_product", prod_m, 32'd0);
      check("midcalc_rst_busy", 32'(busy_m), 32'd0);
      check("midcalc_rst_in_ready", 32'(in_ready_m), 32'd0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("midcalc_ready_again", 32'(in_ready_m), 32'd1);
      check("midcalc_no_output", 32'(out_valid_m), 32'd0);
      do_op(8, 16'd3, 16'd5, 1'b0, 0, 0, 1'b0, r);
      check("after_rst_3x5", r, 32'd15);

      // Corner operands in both modes at every width
      foreach (widths[i]) begin
         for (int s = 0; s < 2; s++) begin
            mn = (s != 0) ? 16'(32'd1 << (widths[i] - 1)) : 16'd0;
            mx = (s != 0) ? 16'((32'd1 << (widths[i] - 1)) - 1) : 16'((32'd1 << widths[i]) - 1);
            do_op(widths[i], 16'd0, 16'($urandom), s[0], 0, 0, 1'b0, r);
            check("zero_x_any", r, 32'd0);
            do_op(widths[i], mn, 16'd1, s[0], 0, 0, 1'b0, r);
            do_op(widths[i], mx, mx, s[0], 0, 0, 1'b0, r);
            do_op(widths[i], mn, mn, s[0], 0, 0, 1'b0, r);
         end
      end

      // Random operations with random input and output gaps
      foreach (widths[i]) begin
         for (int s = 0; s < 2; s++) begin
            for (int k = 0; k < 1000; k++) begin
               pg = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
               hd = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
               do_op(widths[i], 16'($urandom), 16'($urandom), s[0], pg, hd, 1'b0, r);
            end
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
